// File: rtl/dm_banked_dual_port.sv
// Dual-port data memory over 2**NBANK_LOG2 address-interleaved banks.
// Registered reads, execute+1 write commit with bypass, round-robin bank arbitration.
module dm_banked_dual_port #(
  parameter int DMA_SIZE   = 16,
  parameter int DMD_SIZE   = 16,
  parameter int NBANK_LOG2 = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_cslt,
  input  logic                a_wrb,
  input  logic [DMA_SIZE-1:0] a_add,
  input  logic [DMD_SIZE-1:0] a_dt_in,
  output logic [DMD_SIZE-1:0] a_dt_out,
  output logic                a_vld,
  output logic                a_stall,
  input  logic                b_cslt,
  input  logic                b_wrb,
  input  logic [DMA_SIZE-1:0] b_add,
  input  logic [DMD_SIZE-1:0] b_dt_in,
  output logic [DMD_SIZE-1:0] b_dt_out,
  output logic                b_vld,
  output logic                b_stall
);

  localparam int unsigned NBANK = 2 ** NBANK_LOG2;
  localparam int unsigned ROWS  = 2 ** (DMA_SIZE - NBANK_LOG2);
  localparam int          RW    = DMA_SIZE - NBANK_LOG2;

  typedef enum logic {PRIO_A, PRIO_B} prio_e;

  prio_e                 prio_q, prio_d;
  logic                  pa_vld_q, pa_vld_d, pb_vld_q, pb_vld_d;
  logic [DMA_SIZE-1:0]   pa_add_q, pa_add_d, pb_add_q, pb_add_d;
  logic [DMD_SIZE-1:0]   a_dt_out_q, a_dt_out_d, b_dt_out_q, b_dt_out_d;
  logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;

  logic [DMD_SIZE-1:0]   mem [NBANK][ROWS];

  logic [NBANK_LOG2-1:0] a_bank, b_bank, pa_bank, pb_bank;
  logic [RW-1:0]         a_row, b_row, pa_row, pb_row;
  logic                  conflict, a_acc, b_acc;
  logic [DMD_SIZE-1:0]   a_rdata, b_rdata;
  logic [NBANK-1:0]      wr_en;
  logic [RW-1:0]         wr_row  [NBANK];
  logic [DMD_SIZE-1:0]   wr_data [NBANK];

  always_comb begin
    a_bank  = a_add[NBANK_LOG2-1:0];
    a_row   = a_add[DMA_SIZE-1:NBANK_LOG2];
    b_bank  = b_add[NBANK_LOG2-1:0];
    b_row   = b_add[DMA_SIZE-1:NBANK_LOG2];
    pa_bank = pa_add_q[NBANK_LOG2-1:0];
    pa_row  = pa_add_q[DMA_SIZE-1:NBANK_LOG2];
    pb_bank = pb_add_q[NBANK_LOG2-1:0];
    pb_row  = pb_add_q[DMA_SIZE-1:NBANK_LOG2];
  end

  always_comb begin
    conflict = a_cslt && b_cslt && (a_bank == b_bank);
    a_stall  = !reset && conflict && (prio_q == PRIO_B);
    b_stall  = !reset && conflict && (prio_q == PRIO_A);
    a_acc    = !reset && a_cslt && !a_stall;
    b_acc    = !reset && b_cslt && !b_stall;
    prio_d   = prio_q;
    if (conflict)
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
  end

  // Same-bank accepts never coincide, so the two pending commits always target different banks.
  always_comb begin
    wr_en = '0;
    for (int unsigned g = 0; g < NBANK; g++) begin
      wr_row[g]  = '0;
      wr_data[g] = '0;
    end
    if (pa_vld_q && !reset) begin
      wr_en[pa_bank]   = 1'b1;
      wr_row[pa_bank]  = pa_row;
      wr_data[pa_bank] = a_dt_in;
    end
    if (pb_vld_q && !reset) begin
      wr_en[pb_bank]   = 1'b1;
      wr_row[pb_bank]  = pb_row;
      wr_data[pb_bank] = b_dt_in;
    end
  end

  // A read hitting a write committing this cycle takes the in-flight data; at most one can match.
  always_comb begin
    a_rdata = mem[a_bank][a_row];
    if (pa_vld_q && (pa_add_q == a_add))
      a_rdata = a_dt_in;
    else if (pb_vld_q && (pb_add_q == a_add))
      a_rdata = b_dt_in;
    b_rdata = mem[b_bank][b_row];
    if (pa_vld_q && (pa_add_q == b_add))
      b_rdata = a_dt_in;
    else if (pb_vld_q && (pb_add_q == b_add))
      b_rdata = b_dt_in;
  end

  always_comb begin
    pa_vld_d   = a_acc && a_wrb;
    pb_vld_d   = b_acc && b_wrb;
    pa_add_d   = a_acc ? a_add : pa_add_q;
    pb_add_d   = b_acc ? b_add : pb_add_q;
    a_vld_d    = a_acc && !a_wrb;
    b_vld_d    = b_acc && !b_wrb;
    a_dt_out_d = a_vld_d ? a_rdata : a_dt_out_q;
    b_dt_out_d = b_vld_d ? b_rdata : b_dt_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= PRIO_A;
      pa_vld_q   <= 1'b0;
      pb_vld_q   <= 1'b0;
      pa_add_q   <= '0;
      pb_add_q   <= '0;
      a_dt_out_q <= '0;
      b_dt_out_q <= '0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      pa_vld_q   <= pa_vld_d;
      pb_vld_q   <= pb_vld_d;
      pa_add_q   <= pa_add_d;
      pb_add_q   <= pb_add_d;
      a_dt_out_q <= a_dt_out_d;
      b_dt_out_q <= b_dt_out_d;
      a_vld_q    <= a_vld_d;
      b_vld_q    <= b_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned g = 0; g < NBANK; g++)
      if (wr_en[g])
        mem[g][wr_row[g]] <= wr_data[g];
  end

  always_comb begin
    a_dt_out = a_dt_out_q;
    b_dt_out = b_dt_out_q;
    a_vld    = a_vld_q;
    b_vld    = b_vld_q;
  end

endmodule

// File: tb/tb_dm_banked_dual_port.sv
// Directed bench for dm_banked_dual_port; expected read data queued per port at request time.
module tb_dm_banked_dual_port;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_cslt, a_wrb, b_cslt, b_wrb;
  logic [AW-1:0] a_add, b_add;
  logic [DW-1:0] a_dt_in, b_dt_in, a_dt_out, b_dt_out;
  logic          a_vld, b_vld, a_stall, b_stall;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] a_q [$];
  logic [DW-1:0] b_q [$];
  logic [DW-1:0] a_last, b_last;

  always #5 clk = ~clk;

  dm_banked_dual_port #(
    .DMA_SIZE  (AW),
    .DMD_SIZE  (DW),
    .NBANK_LOG2(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a_cslt  (a_cslt),
    .a_wrb   (a_wrb),
    .a_add   (a_add),
    .a_dt_in (a_dt_in),
    .a_dt_out(a_dt_out),
    .a_vld   (a_vld),
    .a_stall (a_stall),
    .b_cslt  (b_cslt),
    .b_wrb   (b_wrb),
    .b_add   (b_add),
    .b_dt_in (b_dt_in),
    .b_dt_out(b_dt_out),
    .b_vld   (b_vld),
    .b_stall (b_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic c, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_cslt = c; a_wrb = w; a_add = ad; a_dt_in = d;
  endtask

  task automatic drv_b(input logic c, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_cslt = c; b_wrb = w; b_add = ad; b_dt_in = d;
  endtask

  task automatic idle();
    a_cslt = 1'b0; a_wrb = 1'b0;
    b_cslt = 1'b0; b_wrb = 1'b0;
  endtask

  task automatic stall(input logic ea, input logic eb);
    #1;
    check("a_stall", {31'd0, a_stall}, {31'd0, ea});
    check("b_stall", {31'd0, b_stall}, {31'd0, eb});
  endtask

  // Advance one clock; a queued entry means a read was accepted in the cycle just ended.
  task automatic tick();
    logic ea, eb;
    ea = (a_q.size() > 0);
    eb = (b_q.size() > 0);
    @(posedge clk);
    #1;
    check("a_vld", {31'd0, a_vld}, {31'd0, ea});
    if (ea) a_last = a_q.pop_front();
    check("a_dt_out", {16'd0, a_dt_out}, {16'd0, a_last});
    check("b_vld", {31'd0, b_vld}, {31'd0, eb});
    if (eb) b_last = b_q.pop_front();
    check("b_dt_out", {16'd0, b_dt_out}, {16'd0, b_last});
  endtask

  initial begin
    a_last = '0;
    b_last = '0;
    reset  = 1'b1;
    drv_a(1'b1, 1'b0, 16'h0000, 16'h0);
    drv_b(1'b1, 1'b0, 16'h0010, 16'h0);
    stall(1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    idle();

    // preload 0x0001, 0x0010, 0x000C
    drv_a(1'b1, 1'b1, 16'h0001, 16'h0);
    drv_b(1'b1, 1'b1, 16'h0010, 16'h0);
    stall(1'b0, 1'b0);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0101);
    drv_b(1'b0, 1'b0, 16'h0, 16'h0F0F);
    tick();
    drv_b(1'b1, 1'b1, 16'h000C, 16'h0);
    tick();
    drv_b(1'b0, 1'b0, 16'h0, 16'hC0C0);
    tick();

    // write then read, same port
    drv_a(1'b1, 1'b1, 16'h0004, 16'h0);
    stall(1'b0, 1'b0);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'h1234);
    tick();
    drv_a(1'b1, 1'b0, 16'h0004, 16'h0);
    a_q.push_back(16'h1234);
    tick();
    idle();
    tick();

    // same-port bypass
    drv_a(1'b1, 1'b1, 16'h000A, 16'h0);
    tick();
    drv_a(1'b1, 1'b0, 16'h000A, 16'h7777);
    a_q.push_back(16'h7777);
    tick();
    idle();
    tick();

    // cross-port bypass, then array read
    drv_a(1'b1, 1'b1, 16'h0006, 16'h0);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'hBEEF);
    drv_b(1'b1, 1'b0, 16'h0006, 16'h0);
    b_q.push_back(16'hBEEF);
    stall(1'b0, 1'b0);
    tick();
    idle();
    drv_b(1'b1, 1'b0, 16'h0006, 16'h0);
    b_q.push_back(16'hBEEF);
    tick();
    idle();

    // different banks: A read bank 1, B write bank 0
    drv_a(1'b1, 1'b0, 16'h0001, 16'h0);
    drv_b(1'b1, 1'b1, 16'h0002, 16'h0);
    a_q.push_back(16'h0101);
    stall(1'b0, 1'b0);
    tick();
    idle();
    drv_b(1'b0, 1'b0, 16'h0, 16'h00AA);
    tick();

    // bank-0 conflict, round-robin priority
    drv_a(1'b1, 1'b0, 16'h0002, 16'h0);
    drv_b(1'b1, 1'b0, 16'h0010, 16'h0);
    stall(1'b0, 1'b1);
    a_q.push_back(16'h00AA);
    tick();
    stall(1'b1, 1'b0);
    b_q.push_back(16'h0F0F);
    tick();
    drv_b(1'b0, 1'b0, 16'h0, 16'h0);
    stall(1'b0, 1'b0);
    a_q.push_back(16'h00AA);
    tick();
    idle();

    // simultaneous writes to 0x0008: second-accepted (B) wins
    drv_a(1'b1, 1'b1, 16'h0008, 16'h0);
    drv_b(1'b1, 1'b1, 16'h0008, 16'h0);
    stall(1'b0, 1'b1);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'h1111);
    stall(1'b0, 1'b0);
    tick();
    drv_b(1'b0, 1'b0, 16'h0, 16'h2222);
    tick();
    idle();
    drv_a(1'b1, 1'b0, 16'h0008, 16'h0);
    a_q.push_back(16'h2222);
    tick();
    idle();

    // priority is B now: A loses, then priority returns to A
    drv_a(1'b1, 1'b0, 16'h0004, 16'h0);
    drv_b(1'b1, 1'b0, 16'h0006, 16'h0);
    stall(1'b1, 1'b0);
    b_q.push_back(16'hBEEF);
    tick();
    drv_b(1'b0, 1'b0, 16'h0, 16'h0);
    stall(1'b0, 1'b0);
    a_q.push_back(16'h1234);
    tick();
    // one more conflict leaves priority at B before reset
    drv_a(1'b1, 1'b0, 16'h0006, 16'h0);
    drv_b(1'b1, 1'b0, 16'h0004, 16'h0);
    stall(1'b0, 1'b1);
    a_q.push_back(16'hBEEF);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);
    stall(1'b0, 1'b0);
    b_q.push_back(16'h1234);
    tick();
    idle();

    // reset during a pending write's data cycle
    drv_a(1'b1, 1'b1, 16'h000C, 16'h0);
    stall(1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drv_a(1'b1, 1'b0, 16'h0002, 16'h5555);
    drv_b(1'b1, 1'b0, 16'h0004, 16'h0);
    a_last = '0;
    b_last = '0;
    stall(1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drv_a(1'b1, 1'b0, 16'h000C, 16'h0);
    drv_b(1'b1, 1'b0, 16'h0006, 16'h0);
    stall(1'b0, 1'b1);
    a_q.push_back(16'hC0C0);
    tick();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);
    stall(1'b0, 1'b0);
    b_q.push_back(16'hBEEF);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
